e_md_scheduler: RTL and testbench
=================================

# e_md_scheduler

- Execute-stage controller for the multiply/divide resource used by mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- It accepts one HI/LO operation per cycle from the E stage and models the multi-cycle multiply/divide latency with a busy counter.
- It owns the HI and LO registers and drives the D-stage stall that keeps any later HI/LO instruction out of E while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, default 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- E_md_op  in  4  operation in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; values 9..15 are treated as none.
- E_rs_data  in  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source).
- E_rt_data  in  32  forwarded rt value (divisor / multiplier).
- D_md_use  in  1  decoded D-stage instruction is any of the eight HI/LO ops.
- E_md_out  out  32  HI for op 7, LO for op 8, otherwise 0; combinational from the current registers.
- md_busy  out  1  unit is counting (state != IDLE).
- md_stall  out  1  equals D_md_use & (md_busy | E_start).
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

## Operation
- Start condition: E_start = (E_md_op is 1..4) & ~md_busy.
- State machine:
  - States are IDLE, MULT and DIV, with a 4-bit down-counter cnt.
  - IDLE: on E_start, latch the operands, compute the 64-bit result into pending registers p_hi/p_lo, and go to MULT or DIV with cnt = MULT_CYCLES or DIV_CYCLES.
  - MULT/DIV: decrement cnt each cycle.
  - When cnt == 1, commit hi <= p_hi and lo <= p_lo, and go to IDLE.
- Arithmetic:
  - mult: signed 32x32 to 64 bits.
  - multu: unsigned 32x32 to 64 bits.
  - For both, hi = result[63:32] and lo = result[31:0].
  - div/divu: lo = quotient and hi = remainder. The signed quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): lo = 0x80000000, hi = 0.
- Divide by zero (div or divu): the operation still occupies the unit for DIV_CYCLES, and the commit leaves hi and lo unchanged.
- mthi/mtlo when idle: write hi (or lo) = E_rs_data at the edge. These ops are single cycle and never set md_busy.
- Any op 1..6 arriving while md_busy is a protocol violation; md_stall prevents it.
  - It is ignored: no state change and no write.
  - The bench flags it with an assertion.
- mfhi/mflo while busy: also a violation. E_md_out still reflects the current (old) registers.
- hi and lo change only at a commit edge, an mthi/mtlo edge, or reset.

## Timing
- Reset values: hi = 0, lo = 0, state = IDLE, cnt = 0, md_busy = 0, md_stall = 0, E_md_out = 0.
- Latency: for a mult in E at cycle t, md_busy = 1 in cycles t+1 through t+MULT_CYCLES. The new hi/lo are visible from cycle t+MULT_CYCLES+1, the same cycle md_busy returns to 0. Division behaves identically with DIV_CYCLES.
- md_stall is combinational. It is asserted in cycle t if D holds an HI/LO op, and it stays asserted through the last busy cycle. The D instruction enters E in the first cycle that md_busy = 0.
- Back-to-back: a start is accepted in the first cycle after md_busy falls. There are no idle bubbles beyond the stall.
- Reset asserted mid-operation: the state is aborted at once, the pending result is discarded, hi/lo go to 0, and md_busy = 0 while reset is low. The first start is accepted on the first rising edge after reset rises.
- mthi in the same cycle as the final commit edge cannot occur, because the violation rule blocks it (md_busy is still 1). The commit wins.

## Test plan
- Reset, then mult with rs = 0xFFFFFFFF and rt = 0x00000002 at cycle t:
  - md_busy is high for cycles t+1..t+5.
  - At t+6: hi = 0xFFFFFFFF and lo = 0xFFFFFFFE.
- multu with the same operands: hi = 0x00000001 and lo = 0xFFFFFFFE after 5 busy cycles.
- div with rs = 0xFFFFFFF9 (-7) and rt = 2:
  - busy lasts 10 cycles.
  - Result: lo = 0xFFFFFFFD and hi = 0xFFFFFFFF.
- divu with rs = 7 and rt = 0, issued after mthi 0x1234 and mtlo 0x5678:
  - busy lasts 10 cycles.
  - hi = 0x1234 and lo = 0x5678 remain unchanged.
- mult in E with D_md_use = 1 (mflo):
  - md_stall is 1 from t through t+5 and 0 at t+6.
  - mflo issued at t+6 returns E_md_out = the new lo.
- div started, then reset pulled low at busy cycle 4:
  - hi = lo = 0 and md_busy = 0 immediately.
  - After release, mtlo 0xA5A5A5A5 gives lo = 0xA5A5A5A5 at the next edge.

Source files
------------

// File: rtl/e_md_scheduler.sv
// Execute-stage multiply/divide scheduler: owns HI/LO, models unit latency with a
// busy down-counter and raises the D-stage stall for dependent HI/LO instructions.
module e_md_scheduler #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_md_op,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   input  logic        D_md_use,
   output logic [31:0] E_md_out,
   output logic        md_busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] p_hi_q, p_hi_d;
   logic [31:0] p_lo_q, p_lo_d;
   logic        p_skip_q, p_skip_d;

   logic        e_start;
   logic        div_zero;
   logic [31:0] rt_safe;
   logic signed [63:0] rs_s64;
   logic signed [63:0] rt_s64;
   logic signed [63:0] rt_safe_s64;
   logic signed [63:0] prod_s;
   logic [63:0] prod_u;

   // Operands are widened to 64 bits so the signed overflow case
   // 0x80000000 / -1 wraps cleanly to 0x80000000 with remainder 0.
   always_comb begin
      div_zero    = (E_rt_data == 32'd0);
      rt_safe     = div_zero ? 32'd1 : E_rt_data;
      rs_s64      = {{32{E_rs_data[31]}}, E_rs_data};
      rt_s64      = {{32{E_rt_data[31]}}, E_rt_data};
      rt_safe_s64 = {{32{rt_safe[31]}}, rt_safe};
      prod_s      = rs_s64 * rt_s64;
      prod_u      = {32'd0, E_rs_data} * {32'd0, E_rt_data};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      p_hi_d   = p_hi_q;
      p_lo_d   = p_lo_q;
      p_skip_d = p_skip_q;

      md_busy  = (state_q != ST_IDLE);
      e_start  = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU) && !md_busy;
      md_stall = D_md_use && (md_busy || e_start);

      unique case (E_md_op)
         OP_MFHI: E_md_out = hi_q;
         OP_MFLO: E_md_out = lo_q;
         default: E_md_out = 32'd0;
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (e_start) begin
               p_skip_d = 1'b0;
               unique case (E_md_op)
                  OP_MULT: begin
                     p_hi_d  = prod_s[63:32];
                     p_lo_d  = prod_s[31:0];
                     state_d = ST_MULT;
                     cnt_d   = 4'(MULT_CYCLES);
                  end
                  OP_MULTU: begin
                     p_hi_d  = prod_u[63:32];
                     p_lo_d  = prod_u[31:0];
                     state_d = ST_MULT;
                     cnt_d   = 4'(MULT_CYCLES);
                  end
                  OP_DIV: begin
                     p_lo_d   = 32'(rs_s64 / rt_safe_s64);
                     p_hi_d   = 32'(rs_s64 % rt_safe_s64);
                     p_skip_d = div_zero;
                     state_d  = ST_DIV;
                     cnt_d    = 4'(DIV_CYCLES);
                  end
                  default: begin
                     p_lo_d   = E_rs_data / rt_safe;
                     p_hi_d   = E_rs_data % rt_safe;
                     p_skip_d = div_zero;
                     state_d  = ST_DIV;
                     cnt_d    = 4'(DIV_CYCLES);
                  end
               endcase
            end else if (E_md_op == OP_MTHI) begin
               hi_d = E_rs_data;
            end else if (E_md_op == OP_MTLO) begin
               lo_d = E_rs_data;
            end
         end
         default: begin
            // A zero count can only come from an illegal parameter; treat it as done.
            if (cnt_q <= 4'd1) begin
               if (!p_skip_q) begin
                  hi_d = p_hi_q;
                  lo_d = p_lo_q;
               end
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         p_hi_q   <= 32'd0;
         p_lo_q   <= 32'd0;
         p_skip_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         p_hi_q   <= p_hi_d;
         p_lo_q   <= p_lo_d;
         p_skip_q <= p_skip_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_e_md_scheduler.sv
// Randomized self-checking bench for e_md_scheduler against a behavioural model
// that tracks HI/LO, the remaining busy cycles and the pending result.
module tb_e_md_scheduler;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  E_md_op;
   logic [31:0] E_rs_data;
   logic [31:0] E_rt_data;
   logic        D_md_use;
   logic [31:0] E_md_out;
   logic        md_busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   e_md_scheduler #(
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .E_md_op   (E_md_op),
      .E_rs_data (E_rs_data),
      .E_rt_data (E_rt_data),
      .D_md_use  (D_md_use),
      .E_md_out  (E_md_out),
      .md_busy   (md_busy),
      .md_stall  (md_stall),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Model state: architectural registers, busy cycles still to run, pending result.
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   int          m_cnt;
   bit          m_dz;

   int num_vectors;
   int num_miscompares;

   // HI/LO ops issued into a busy unit are protocol violations.
   always @(negedge clk) begin
      if (reset === 1'b1 && md_busy === 1'b1)
         assert (!(E_md_op >= 4'd1 && E_md_op <= 4'd8))
            else $error("[TB] protocol violation: HI/LO op %0d issued while busy", E_md_op);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_vectors++;
      if (observed !== expected) begin
         num_miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic bit isStartOp(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd4);
   endfunction

   task automatic checkAll();
      bit          busy_exp;
      bit          stall_exp;
      logic [31:0] out_exp;
      busy_exp  = (m_cnt > 0);
      stall_exp = D_md_use && (busy_exp || isStartOp(E_md_op));
      out_exp   = (E_md_op == 4'd7) ? m_hi : (E_md_op == 4'd8) ? m_lo : 32'd0;
      checkOutput("md_busy",  {31'd0, md_busy},  {31'd0, busy_exp});
      checkOutput("md_stall", {31'd0, md_stall}, {31'd0, stall_exp});
      checkOutput("E_md_out", E_md_out, out_exp);
      checkOutput("hi", hi, m_hi);
      checkOutput("lo", lo, m_lo);
   endtask

   // Advance the model across one rising edge using the inputs held during the cycle.
   task automatic modelEdge();
      longint a, b, p;
      logic [63:0] pu;
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0 && !m_dz) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (isStartOp(E_md_op)) begin
         a = longint'($signed(E_rs_data));
         b = longint'($signed(E_rt_data));
         m_dz = 1'b0;
         case (E_md_op)
            4'd1: begin
               p = a * b;
               m_phi = p[63:32];
               m_plo = p[31:0];
               m_cnt = MULT_N;
            end
            4'd2: begin
               pu = {32'd0, E_rs_data} * {32'd0, E_rt_data};
               m_phi = pu[63:32];
               m_plo = pu[31:0];
               m_cnt = MULT_N;
            end
            4'd3: begin
               m_dz = (b == 0);
               if (!m_dz) begin
                  p = a / b;
                  m_plo = p[31:0];
                  p = a % b;
                  m_phi = p[31:0];
               end
               m_cnt = DIV_N;
            end
            default: begin
               m_dz = (E_rt_data == 32'd0);
               if (!m_dz) begin
                  m_plo = E_rs_data / E_rt_data;
                  m_phi = E_rs_data % E_rt_data;
               end
               m_cnt = DIV_N;
            end
         endcase
      end else if (E_md_op == 4'd5) begin
         m_hi = E_rs_data;
      end else if (E_md_op == 4'd6) begin
         m_lo = E_rs_data;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic duse);
      E_md_op   = op;
      E_rs_data = rs;
      E_rt_data = rt;
      D_md_use  = duse;
      #1;
      checkAll();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
   endtask

   // Pull reset low between edges, check the cleared state, then release away from an edge.
   task automatic doReset();
      E_md_op   = 4'd0;
      E_rs_data = 32'd0;
      E_rt_data = 32'd0;
      D_md_use  = 1'b0;
      reset     = 1'b0;
      #1;
      m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0; m_dz = 1'b0;
      checkOutput("rst_hi",       hi,                 32'd0);
      checkOutput("rst_lo",       lo,                 32'd0);
      checkOutput("rst_busy",     {31'd0, md_busy},   32'd0);
      checkOutput("rst_stall",    {31'd0, md_stall},  32'd0);
      checkOutput("rst_E_md_out", E_md_out,           32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
   endtask

   function automatic logic [31:0] pickOperand();
      logic [31:0] specials [6];
      specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
      return $urandom();
   endfunction

   initial begin
      logic [3:0] op;
      num_vectors     = 0;
      num_miscompares = 0;
      m_phi = 32'd0; m_plo = 32'd0;
      doReset();

      // Signed multiply of -1 by 2.
      applyStimulus(4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
      idleCycles(MULT_N);
      checkOutput("mult_hi", hi, 32'hFFFFFFFF);
      checkOutput("mult_lo", lo, 32'hFFFFFFFE);

      applyStimulus(4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0);
      idleCycles(MULT_N);
      checkOutput("multu_hi", hi, 32'h00000001);
      checkOutput("multu_lo", lo, 32'hFFFFFFFE);

      applyStimulus(4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      idleCycles(DIV_N);
      checkOutput("div_hi", hi, 32'hFFFFFFFF);
      checkOutput("div_lo", lo, 32'hFFFFFFFD);

      // Divide by zero keeps the previously written HI/LO.
      applyStimulus(4'd5, 32'h00001234, 32'd0, 1'b0);
      applyStimulus(4'd6, 32'h00005678, 32'd0, 1'b0);
      applyStimulus(4'd4, 32'h00000007, 32'd0, 1'b0);
      idleCycles(DIV_N);
      checkOutput("divz_hi", hi, 32'h00001234);
      checkOutput("divz_lo", lo, 32'h00005678);

      applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      idleCycles(DIV_N);
      checkOutput("divovf_hi", hi, 32'h00000000);
      checkOutput("divovf_lo", lo, 32'h80000000);

      // Stall while an mflo waits in D, then the mflo sees the new LO.
      applyStimulus(4'd1, 32'h00000003, 32'h00000007, 1'b1);
      for (int i = 0; i < MULT_N; i++) applyStimulus(4'd0, 32'd0, 32'd0, 1'b1);
      applyStimulus(4'd8, 32'd0, 32'd0, 1'b0);
      checkOutput("mflo_val", lo, 32'd21);

      // Reset during the fourth busy cycle of a divide.
      applyStimulus(4'd3, 32'h00000064, 32'h00000007, 1'b0);
      idleCycles(3);
      doReset();
      applyStimulus(4'd6, 32'hA5A5A5A5, 32'd0, 1'b0);
      checkOutput("mtlo_after_rst", lo, 32'hA5A5A5A5);

      for (int i = 0; i < 600; i++) begin
         if (m_cnt > 0) begin
            op = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(1, 7)) : 4'd0;
         end else begin
            op = 4'($urandom_range(0, 15));
         end
         applyStimulus(op, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)));
      end
      idleCycles(DIV_N + 1);

      $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
      $finish;
   end

endmodule
